// File: rtl/gmii_pkg.sv
// ---------------------------------------------------------------------------
// gmii_pkg
// Shared constants, frame layout byte indices, transmit FSM encoding and the
// IPv4 header checksum helper for the GMII video transmit/receive paths.
// No ports (package).
// ---------------------------------------------------------------------------
package gmii_pkg;

    localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  IP_VER_IHL    = 8'h45;
    localparam logic [7:0]  IP_TOS        = 8'h00;
    localparam logic [7:0]  IP_TTL        = 8'h40;
    localparam logic [7:0]  IP_PROTO_UDP  = 8'h11;
    localparam logic [15:0] IP_FLAGS_FRAG = 16'h4000;
    localparam logic [15:0] IP_TOTAL_LEN  = 16'd1231;
    localparam logic [15:0] UDP_LEN       = 16'd1211;

    localparam logic [7:0]  PKT_VIDEO     = 8'h00;
    localparam logic [7:0]  PKT_AUDIO     = 8'h01;
    localparam logic [7:0]  PKT_VIDAX     = 8'h02;

    // Byte indices, counted from the first preamble byte.
    localparam logic [10:0] PAYLOAD_BYTES = 11'd1200;
    localparam logic [10:0] HDR_END       = 11'd52;
    localparam logic [10:0] PAY_LAST      = HDR_END + PAYLOAD_BYTES;  // 1252
    localparam logic [10:0] RD_LAST       = PAY_LAST - 11'd2;         // 1250
    localparam logic [10:0] CRC_FIRST     = 11'd8;
    localparam logic [10:0] FRAME_LAST    = 11'd1256;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FRAME = 2'd1,
        ST_FCS   = 2'd2,
        ST_GAP   = 2'd3
    } tx_state_e;

    // Ones-complement header checksum; every header word except the
    // identification and the addresses is a constant.
    function automatic logic [15:0] ip_csum(input logic [15:0] ident,
                                            input logic [31:0] src,
                                            input logic [31:0] dst);
        logic [19:0] sum;
        sum = {4'h0, IP_VER_IHL, IP_TOS} + {4'h0, IP_TOTAL_LEN} + {4'h0, ident}
            + {4'h0, IP_FLAGS_FRAG} + {4'h0, IP_TTL, IP_PROTO_UDP}
            + {4'h0, src[31:16]} + {4'h0, src[15:0]}
            + {4'h0, dst[31:16]} + {4'h0, dst[15:0]};
        sum = {4'h0, sum[15:0]} + {16'h0000, sum[19:16]};
        sum = {4'h0, sum[15:0]} + {16'h0000, sum[19:16]};
        return ~sum[15:0];
    endfunction

endpackage

// File: rtl/crc32_d8.sv
// ---------------------------------------------------------------------------
// crc32_d8
// Byte-wide next-state function of the reflected Ethernet CRC-32
// (polynomial 0x04C11DB7, reflected form 0xEDB88320). Purely combinational;
// data bit 0 is processed first.
// Ports:
//   crc      in  32  current CRC register
//   data     in  8   byte being absorbed
//   crc_next out 32  CRC after absorbing data
// ---------------------------------------------------------------------------
module crc32_d8
(
    input  logic [31:0] crc,
    input  logic [7:0]  data,
    output logic [31:0] crc_next
);

    logic [31:0] crc_v_s;

    // Eight serial LFSR steps unrolled into one combinational cone.
    always_comb begin
        crc_v_s = crc;
        for (int i = 0; i < 8; i++) begin
            if (crc_v_s[0] ^ data[i]) begin
                crc_v_s = {1'b0, crc_v_s[31:1]} ^ 32'hEDB88320;
            end else begin
                crc_v_s = {1'b0, crc_v_s[31:1]};
            end
        end
        crc_next = crc_v_s;
    end

endmodule

// File: rtl/gmii_video_tx.sv
// ---------------------------------------------------------------------------
// gmii_video_tx
// Sends one Ethernet/IPv4/UDP video frame (1200 payload bytes read as 600
// 16-bit FIFO words) per accepted request on a 125 MHz GMII TX interface.
// Optional build macro IPV4_CSUM_EN: when defined the IPv4 header checksum is
// computed, otherwise the checksum field is sent as zero.
// Ports:
//   clk125     in  1   GMII TX clock
//   sys_rst_n  in  1   asynchronous active-low reset
//   id         in  1   receiver select, added to the destination IP last octet
//   tx_req     in  1   line segment ready (level)
//   y_info     in  12  line number, latched on tx_ack
//   x_info     in  4   segment index, latched on tx_ack
//   tx_ack     out 1   one-cycle request-accepted pulse
//   busy       out 1   frame in progress / inter-frame gap running
//   fifo_dout  in  16  pixel word, valid the cycle after fifo_rd_en
//   fifo_empty in  1   FIFO empty
//   fifo_rd_en out 1   FIFO read strobe
//   underflow  out 1   one-cycle pulse: FIFO empty when a read was due
//   txd        out 8   GMII TX data
//   tx_en      out 1   GMII TX enable
// ---------------------------------------------------------------------------
module gmii_video_tx
    import gmii_pkg::*;
#(
    parameter logic [47:0] src_mac   = 48'h00_11_22_33_44_55,
    parameter logic [47:0] dst_mac   = 48'hFF_FF_FF_FF_FF_FF,
    parameter logic [31:0] ipv4_src  = {8'd192, 8'd168, 8'd0, 8'd2},
    parameter logic [31:0] ipv4_dst  = {8'd192, 8'd168, 8'd0, 8'd1},
    parameter logic [15:0] src_port  = 16'd12345,
    parameter logic [15:0] dst_port  = 16'd12345,
    parameter logic [7:0]  ifg_bytes = 8'd12
)
(
    input  logic        clk125,
    input  logic        sys_rst_n,
    input  logic        id,
    input  logic        tx_req,
    input  logic [11:0] y_info,
    input  logic [3:0]  x_info,
    output logic        tx_ack,
    output logic        busy,
    input  logic [15:0] fifo_dout,
    input  logic        fifo_empty,
    output logic        fifo_rd_en,
    output logic        underflow,
    output logic [7:0]  txd,
    output logic        tx_en
);

    tx_state_e   state_r;
    logic [10:0] bc_r;
    logic [10:0] nbc_s;
    logic [7:0]  gap_cnt_r;
    logic [7:0]  txd_r;
    logic        hi_sel_r;
    logic        zero_word_r;
    logic        tx_en_r;
    logic        tx_ack_r;
    logic        busy_r;
    logic        fifo_rd_en_r;
    logic        underflow_r;
    logic [15:0] ident_r;
    logic [11:0] y_r;
    logic [3:0]  x_r;
    logic        id_r;
    logic [15:0] csum_s;
    logic [31:0] crc_r;
    logic [31:0] crc_next_s;
    logic [7:0]  txd_s;
    logic [7:0]  dst_lo_s;
    logic [5:0]  hdr_idx_s;
    logic [423:0] hdr_s;
    logic [7:0]  hdr_byte_s;

    assign nbc_s    = bc_r + 11'd1;
    assign dst_lo_s = ipv4_dst[7:0] + {7'd0, id_r};

    // Bytes 0..52 as one vector, byte 0 in the most significant position.
    assign hdr_s = {{7{8'h55}}, 8'hD5, dst_mac, src_mac, ETH_TYPE_IPV4,
                    IP_VER_IHL, IP_TOS, IP_TOTAL_LEN, ident_r, IP_FLAGS_FRAG,
                    IP_TTL, IP_PROTO_UDP, csum_s, ipv4_src, ipv4_dst[31:8], dst_lo_s,
                    src_port, dst_port, UDP_LEN, 16'h0000,
                    PKT_VIDEO, y_r[7:0], x_r, y_r[11:8]};
    assign hdr_idx_s  = 6'd52 - nbc_s[5:0];
    assign hdr_byte_s = hdr_s[{hdr_idx_s, 3'b000} +: 8];

`ifdef IPV4_CSUM_EN
    logic [15:0] csum_r;

    // Checksum captured at request acceptance, long before its byte slot.
    always_ff @(posedge clk125 or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            csum_r <= 16'h0000;
        end else if ((state_r == ST_IDLE) && tx_req) begin
            csum_r <= ip_csum(ident_r, ipv4_src,
                              {ipv4_dst[31:8], ipv4_dst[7:0] + {7'd0, id}});
        end
    end

    assign csum_s = csum_r;
`else
    assign csum_s = 16'h0000;
`endif

    // The FIFO word arrives one cycle after the read strobe, i.e. in the
    // very cycle its high byte is due, so the high byte bypasses txd_r.
    always_comb begin
        txd_s = txd_r;
        if (hi_sel_r) begin
            txd_s = zero_word_r ? 8'h00 : fifo_dout[15:8];
        end else begin
            txd_s = txd_r;
        end
    end

    crc32_d8 u_crc32_d8 (
        .crc      (crc_r),
        .data     (txd_s),
        .crc_next (crc_next_s)
    );

    // Transmit FSM: byte sequencing, FIFO reads, FCS and inter-frame gap.
    always_ff @(posedge clk125 or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_r      <= ST_IDLE;
            bc_r         <= 11'd0;
            gap_cnt_r    <= 8'd0;
            txd_r        <= 8'h00;
            hi_sel_r     <= 1'b0;
            zero_word_r  <= 1'b0;
            tx_en_r      <= 1'b0;
            tx_ack_r     <= 1'b0;
            busy_r       <= 1'b0;
            fifo_rd_en_r <= 1'b0;
            underflow_r  <= 1'b0;
            ident_r      <= 16'h0000;
            y_r          <= 12'h000;
            x_r          <= 4'h0;
            id_r         <= 1'b0;
            crc_r        <= 32'hFFFFFFFF;
        end else begin
            tx_ack_r     <= 1'b0;
            fifo_rd_en_r <= 1'b0;
            underflow_r  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (tx_req) begin
                        state_r  <= ST_FRAME;
                        tx_ack_r <= 1'b1;
                        busy_r   <= 1'b1;
                        tx_en_r  <= 1'b1;
                        txd_r    <= 8'h55;
                        hi_sel_r <= 1'b0;
                        bc_r     <= 11'd0;
                        y_r      <= y_info;
                        x_r      <= x_info;
                        id_r     <= id;
                        crc_r    <= 32'hFFFFFFFF;
                    end
                end
                ST_FRAME: begin
                    bc_r <= nbc_s;
                    if (bc_r >= CRC_FIRST) begin
                        crc_r <= crc_next_s;
                    end
                    if (nbc_s <= HDR_END) begin
                        txd_r    <= hdr_byte_s;
                        hi_sel_r <= 1'b0;
                    end else if (nbc_s <= PAY_LAST) begin
                        if (nbc_s[0]) begin
                            hi_sel_r <= 1'b1;
                            txd_r    <= 8'h00;
                        end else begin
                            hi_sel_r <= 1'b0;
                            txd_r    <= zero_word_r ? 8'h00 : fifo_dout[7:0];
                        end
                    end else begin
                        // First FCS byte needs the CRC including byte 1252.
                        hi_sel_r <= 1'b0;
                        txd_r    <= ~crc_next_s[7:0];
                        state_r  <= ST_FCS;
                    end
                    // A read is due on every even byte 52..1250; an empty FIFO
                    // turns that word into zeros instead of stalling.
                    if ((nbc_s >= HDR_END) && (nbc_s <= RD_LAST) && !nbc_s[0]) begin
                        fifo_rd_en_r <= !fifo_empty;
                        underflow_r  <= fifo_empty;
                        zero_word_r  <= fifo_empty;
                    end
                end
                ST_FCS: begin
                    bc_r <= nbc_s;
                    if (bc_r == FRAME_LAST) begin
                        state_r   <= ST_GAP;
                        tx_en_r   <= 1'b0;
                        txd_r     <= 8'h00;
                        gap_cnt_r <= 8'd0;
                        ident_r   <= ident_r + 16'd1;
                    end else begin
                        case (bc_r[1:0])
                            2'b01:   txd_r <= ~crc_r[15:8];
                            2'b10:   txd_r <= ~crc_r[23:16];
                            2'b11:   txd_r <= ~crc_r[31:24];
                            default: txd_r <= 8'h00;
                        endcase
                    end
                end
                ST_GAP: begin
                    // GAP lasts ifg_bytes-1 cycles; the IDLE cycle that samples
                    // tx_req completes the ifg_bytes idle cycles.
                    gap_cnt_r <= gap_cnt_r + 8'd1;
                    if (gap_cnt_r == (ifg_bytes - 8'd3)) begin
                        busy_r <= 1'b0;
                    end
                    if (gap_cnt_r == (ifg_bytes - 8'd2)) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign txd        = txd_s;
    assign tx_en      = tx_en_r;
    assign tx_ack     = tx_ack_r;
    assign busy       = busy_r;
    assign fifo_rd_en = fifo_rd_en_r;
    assign underflow  = underflow_r;

endmodule
